// File: rtl/bsg_fpu_minmax_reduce.sv
// bsg_fpu_minmax_reduce: streaming min/max reduction over float packets.
//
// Accepts one element per cycle and folds it into running min/max
// accumulators using bsg_fpu_cmp. It holds the packet result until the
// consumer takes it.
//
// Ports (w = e_p+m_p+1):
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   v_i, data_i[w], last_i   input element handshake (transfer = v_i & ready_o)
//   ready_o                  stage accepting elements (IDLE/ACCUM)
//   v_o, yumi_i              result valid / result consumed
//   min_o, max_o [w]         packet minimum / maximum
//   count_o [cnt_width_p]    saturating element count
//   invalid_o                sticky: some element was a signalling NaN
//
// Optional feature macro BSG_FPU_MINMAX_REDUCE_ARGIDX_EN adds
//   argmin_o, argmax_o [cnt_width_p]: 0-based index of the min/max element.

// bsg_fpu_cmp: min/max of two floats with IEEE minNum/maxNum NaN handling.
module bsg_fpu_cmp #(
    parameter int e_p = 5,
    parameter int m_p = 10
) (
    input  logic [e_p+m_p:0] a_i,
    input  logic [e_p+m_p:0] b_i,
    output logic [e_p+m_p:0] min_o,
    output logic [e_p+m_p:0] max_o,
    output logic             min_max_invalid_o
);
    localparam int w = e_p + m_p + 1;
    localparam logic [w-1:0] qnan_lp = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

    logic a_nan, b_nan, a_snan, b_snan, a_mag_lt, b_mag_lt, a_lt_b;

    assign a_nan  = (&a_i[w-2 -: e_p]) & (|a_i[m_p-1:0]);
    assign b_nan  = (&b_i[w-2 -: e_p]) & (|b_i[m_p-1:0]);
    assign a_snan = a_nan & ~a_i[m_p-1];
    assign b_snan = b_nan & ~b_i[m_p-1];
    assign min_max_invalid_o = a_snan | b_snan;

    assign a_mag_lt = a_i[w-2:0] < b_i[w-2:0];
    assign b_mag_lt = b_i[w-2:0] < a_i[w-2:0];
    // Sign-magnitude order; differing signs make -0 strictly below +0.
    assign a_lt_b = (a_i[w-1] != b_i[w-1]) ? a_i[w-1]
                  : (a_i[w-1] ? b_mag_lt : a_mag_lt);

    // Ties resolve as min <- b, max <- a.
    assign min_o = (a_nan & b_nan) ? qnan_lp : a_nan ? b_i : b_nan ? a_i
                 : a_lt_b ? a_i : b_i;
    assign max_o = (a_nan & b_nan) ? qnan_lp : a_nan ? b_i : b_nan ? a_i
                 : a_lt_b ? b_i : a_i;
endmodule

module bsg_fpu_minmax_reduce #(
    parameter int e_p         = 5,
    parameter int m_p         = 10,
    parameter int cnt_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [e_p+m_p:0]       data_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [e_p+m_p:0]       min_o,
    output logic [e_p+m_p:0]       max_o,
    output logic [cnt_width_p-1:0] count_o,
    output logic                   invalid_o,
    input  logic                   yumi_i
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    ,
    output logic [cnt_width_p-1:0] argmin_o,
    output logic [cnt_width_p-1:0] argmax_o
`endif
);
    localparam int w = e_p + m_p + 1;
    localparam logic [w-1:0] qnan_lp = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   ready_q, v_q, invalid_q, invalid_d;
    logic [w-1:0]           min_q, min_d, max_q, max_d;
    logic [w-1:0]           cmp_min, cmp_max;
    logic                   cmp_min_inv, cmp_max_inv;
    logic [cnt_width_p-1:0] count_q, count_d;
    logic                   xfer, clr;

    // The min and max accumulators are distinct registers, so each gets its
    // own comparator against the incoming element (a = accumulator, b = data).
    bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) cmp_min_inst (
        .a_i               (min_q),
        .b_i               (data_i),
        .min_o             (cmp_min),
        .max_o             (),
        .min_max_invalid_o (cmp_min_inv)
    );

    bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) cmp_max_inst (
        .a_i               (max_q),
        .b_i               (data_i),
        .min_o             (),
        .max_o             (cmp_max),
        .min_max_invalid_o (cmp_max_inv)
    );

    assign xfer = v_i & ready_q;
    // ready_q is low in DONE, so v_q alone qualifies the consume.
    assign clr  = v_q & yumi_i;

    always_comb begin
        state_d   = clr ? IDLE : (xfer & last_i) ? DONE : xfer ? ACCUM : state_q;
        min_d     = clr ? qnan_lp : xfer ? cmp_min : min_q;
        max_d     = clr ? qnan_lp : xfer ? cmp_max : max_q;
        count_d   = clr ? '0 : (xfer & ~&count_q) ? count_q + 1'b1 : count_q;
        invalid_d = ~clr & (invalid_q | (xfer & (cmp_min_inv | cmp_max_inv)));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            v_q       <= 1'b0;
            min_q     <= qnan_lp;
            max_q     <= qnan_lp;
            count_q   <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= state_d != DONE;
            v_q       <= state_d == DONE;
            min_q     <= min_d;
            max_q     <= max_d;
            count_q   <= count_d;
            invalid_q <= invalid_d;
        end
    end

    assign ready_o   = ready_q;
    assign v_o       = v_q;
    assign min_o     = min_q;
    assign max_o     = max_q;
    assign count_o   = count_q;
    assign invalid_o = invalid_q;

`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    logic [cnt_width_p-1:0] argmin_q, argmin_d, argmax_q, argmax_d;

    // count_q is the index of the incoming element; it saturates, which
    // pins late indices at all-ones. Only a changed bit pattern moves the
    // index, so repeats keep the earliest one.
    always_comb begin
        argmin_d = clr ? '0 : (xfer & (cmp_min != min_q)) ? count_q : argmin_q;
        argmax_d = clr ? '0 : (xfer & (cmp_max != max_q)) ? count_q : argmax_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            argmin_q <= '0;
            argmax_q <= '0;
        end else begin
            argmin_q <= argmin_d;
            argmax_q <= argmax_d;
        end
    end

    assign argmin_o = argmin_q;
    assign argmax_o = argmax_q;
`endif

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);
endmodule

// File: tb/tb_bsg_fpu_minmax_reduce.sv
// tb_bsg_fpu_minmax_reduce: table-driven scoreboard bench for bsg_fpu_minmax_reduce.
module tb_bsg_fpu_minmax_reduce;
    typedef struct {
        logic [0:5][15:0] d;
        int               n;
        logic [15:0]      mn;
        logic [15:0]      mx;
        logic [7:0]       cnt;
        logic             inv;
        logic [7:0]       amin;
        logic [7:0]       amax;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v = 1'b0, last = 1'b0, yumi = 1'b0;
    logic [15:0] data = '0;
    logic        ready, vo, inv;
    logic [15:0] mn, mx;
    logic [7:0]  cnt;
    logic        v2 = 1'b0, last2 = 1'b0;
    logic [15:0] data2 = '0;
    logic        ready2, vo2, inv2;
    logic [15:0] mn2, mx2;
    logic [1:0]  cnt2;
    int          checks = 0;
    int          errors = 0;
    vec_t        tv [6];
    vec_t        sb [$];

`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    logic [7:0] amin, amax;
    logic [1:0] amin2, amax2;
`endif

    always #5 clk = ~clk;

    bsg_fpu_minmax_reduce dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (v),
        .data_i    (data),
        .last_i    (last),
        .ready_o   (ready),
        .v_o       (vo),
        .min_o     (mn),
        .max_o     (mx),
        .count_o   (cnt),
        .invalid_o (inv),
        .yumi_i    (yumi)
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        ,
        .argmin_o  (amin),
        .argmax_o  (amax)
`endif
    );

    bsg_fpu_minmax_reduce #(.cnt_width_p(2)) dut2 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (v2),
        .data_i    (data2),
        .last_i    (last2),
        .ready_o   (ready2),
        .v_o       (vo2),
        .min_o     (mn2),
        .max_o     (mx2),
        .count_o   (cnt2),
        .invalid_o (inv2),
        .yumi_i    (1'b0)
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        ,
        .argmin_o  (amin2),
        .argmax_o  (amax2)
`endif
    );

    function automatic vec_t mk(logic [0:5][15:0] d, int n, logic [15:0] lo, logic [15:0] hi,
                                logic [7:0] c, logic iv, logic [7:0] ai, logic [7:0] ax);
        vec_t t;
        t.d = d; t.n = n; t.mn = lo; t.mx = hi; t.cnt = c; t.inv = iv; t.amin = ai; t.amax = ax;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t t);
        for (int i = 0; i < t.n; i++) begin
            int k;
            v = 1'b1;
            data = t.d[i];
            last = (i == t.n - 1);
            k = 0;
            while (!ready && k < 20) begin
                tick();
                k++;
            end
            if (k == 20) chk("ready_timeout", 0, 1);
            tick();
        end
        v = 1'b0;
        last = 1'b0;
        sb.push_back(t);
    endtask

    task automatic collect();
        vec_t e;
        chk("latency_v_o", vo, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("min", mn, e.mn);
        chk("max", mx, e.mx);
        chk("count", cnt, e.cnt);
        chk("invalid", inv, e.inv);
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        chk("argmin", amin, e.amin);
        chk("argmax", amax, e.amax);
`endif
        chk("done_ready_low", ready, 0);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        chk("post_yumi_ready", ready, 1);
        chk("post_yumi_v_o", vo, 0);
        chk("post_yumi_min", mn, 16'h7E00);
        chk("post_yumi_count", cnt, 0);
    endtask

    initial begin
        tv[0] = mk({16'h3C00, 16'hBC00, 16'h4000, 48'h0}, 3, 16'hBC00, 16'h4000, 3, 0, 1, 2);
        tv[1] = mk({16'h7E00, 16'h7D00, 16'h3C00, 48'h0}, 3, 16'h3C00, 16'h3C00, 3, 1, 2, 2);
        tv[2] = mk({16'h0000, 16'h8000, 64'h0}, 2, 16'h8000, 16'h0000, 2, 0, 1, 0);
        tv[3] = mk({16'h7C00, 80'h0}, 1, 16'h7C00, 16'h7C00, 1, 0, 0, 0);
        tv[4] = mk({16'h7E01, 16'hFE00, 64'h0}, 2, 16'h7E00, 16'h7E00, 2, 0, 0, 0);
        tv[5] = mk({16'h4200, 16'hC500, 16'h0001, 16'hFC00, 32'h0}, 4, 16'hFC00, 16'h4200, 4, 0, 3, 0);

        repeat (3) tick();
        chk("ready_in_reset", ready, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_v_o", vo, 0);
        chk("rst_min", mn, 16'h7E00);
        chk("rst_max", mx, 16'h7E00);
        chk("rst_count", cnt, 0);
        chk("rst_invalid", inv, 0);

        v = 1'b1; data = 16'h7D00; last = 1'b0;
        tick();
        data = 16'h3C00;
        tick();
        v = 1'b0;
        chk("midpkt_count", cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("midpkt_ready_in_reset", ready, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("midpkt_ready", ready, 1);
        chk("midpkt_v_o", vo, 0);
        chk("midpkt_min", mn, 16'h7E00);
        chk("midpkt_max", mx, 16'h7E00);
        chk("midpkt_count_clr", cnt, 0);
        chk("midpkt_invalid", inv, 0);

        for (int i = 0; i < 6; i++) begin
            send(tv[i]);
            collect();
        end

        send(tv[0]);
        v = 1'b1; data = 16'h1234; last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", ready, 0);
            chk("bp_v_o", vo, 1);
            chk("bp_min", mn, 16'hBC00);
            chk("bp_count", cnt, 3);
        end
        v = 1'b0; last = 1'b0;
        collect();
        send(tv[2]);
        collect();

        chk("sat_ready", ready2, 1);
        v2 = 1'b1; data2 = 16'h3C00;
        for (int i = 0; i < 6; i++) begin
            last2 = (i == 5);
            tick();
        end
        v2 = 1'b0; last2 = 1'b0;
        chk("sat_v_o", vo2, 1);
        chk("sat_count", cnt2, 3);
        chk("sat_min", mn2, 16'h3C00);
        chk("sat_invalid", inv2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
